// File: rtl/conv_scheduler.sv
// Convolution line scheduler: sequences a raster pixel stream into the conv
// datapath and tracks which writes produce a result.
// Ports:
//   clk, reset (sync, active-low)        - clock and reset
//   start, abort                         - frame control
//   s_valid/s_ready/s_data               - pixel stream in, raster order
//   cp_we/cp_wr_addr/cp_data/cp_eol      - line-buffer write to the datapath
//   cp_ready                             - datapath window is primed
//   m_valid/m_last                       - result strobe and last-of-frame
//   busy, frame_done                     - status
module conv_scheduler #(
    parameter int DATA_WIDTH    = 16,
    parameter int IMG_WIDTH     = 32,
    parameter int IMG_HEIGHT    = 32,
    parameter int KERNEL_WIDTH  = 3,
    parameter int KERNEL_HEIGHT = 3,
    parameter int PIPE_LATENCY  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  cp_we,
    output logic [13:0]           cp_wr_addr,
    output logic [DATA_WIDTH-1:0] cp_data,
    output logic                  cp_eol,
    output logic                  cp_ready,
    output logic                  m_valid,
    output logic                  m_last,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    // Row counter runs one past the last line after the final pixel.
    localparam int RW = $clog2(IMG_HEIGHT + 1);
    localparam int PL = PIPE_LATENCY;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] COL_RES  = CW'(KERNEL_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_RES  = RW'(KERNEL_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_FILL = RW'(KERNEL_HEIGHT - 2);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        RUN,
        DRAIN,
        DONE
    } state_e;

    state_e state_q, state_d;

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    logic rx_en;
    logic accept;
    logic col_end;
    logic is_result;
    logic is_final;
    logic fill_end;

    logic                  we_q;
    logic                  eol_q;
    logic                  res_q;
    logic                  lastf_q;
    logic [13:0]           addr_q;
    logic [DATA_WIDTH-1:0] data_q;

    logic [PL-1:0] vsh_q, vsh_d;
    logic [PL-1:0] lsh_q, lsh_d;

    assign rx_en     = (state_q == FILL) || (state_q == RUN);
    // Abort wins over a pixel presented in the same cycle.
    assign accept    = rx_en && s_valid && !abort;
    assign col_end   = (col_q == COL_LAST);
    assign is_result = (row_q >= ROW_RES) && (col_q >= COL_RES);
    assign is_final  = (row_q == ROW_LAST) && col_end;
    assign fill_end  = (row_q == ROW_FILL) && col_end;

    assign s_ready    = rx_en;
    assign cp_we      = we_q;
    assign cp_eol     = eol_q;
    assign cp_wr_addr = addr_q;
    assign cp_data    = data_q;
    assign m_valid    = vsh_q[PL-1];
    assign m_last     = lsh_q[PL-1];

    always_comb begin
        state_d    = state_q;
        cp_ready   = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = FILL;
            end
            FILL: begin
                busy = 1'b1;
                if (accept && fill_end) state_d = RUN;
            end
            RUN: begin
                busy     = 1'b1;
                cp_ready = 1'b1;
                if (accept && is_final) state_d = DRAIN;
            end
            DRAIN: begin
                busy     = 1'b1;
                cp_ready = 1'b1;
                if (m_last) state_d = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (state_q == IDLE && start) begin
            col_d = '0;
            row_d = '0;
        end
        if (accept) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
        if (abort) begin
            col_d = '0;
            row_d = '0;
        end
    end

    // res_q sits alongside the write; PL more stages put m_valid
    // PIPE_LATENCY cycles behind cp_we.
    always_comb begin
        vsh_d    = '0;
        lsh_d    = '0;
        vsh_d[0] = res_q;
        lsh_d[0] = lastf_q;
        for (int i = 1; i < PL; i++) begin
            vsh_d[i] = vsh_q[i-1];
            lsh_d[i] = lsh_q[i-1];
        end
        if (abort) begin
            vsh_d = '0;
            lsh_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            we_q    <= 1'b0;
            eol_q   <= 1'b0;
            res_q   <= 1'b0;
            lastf_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            vsh_q   <= '0;
            lsh_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            we_q    <= accept;
            eol_q   <= accept && col_end;
            res_q   <= accept && is_result;
            lastf_q <= accept && is_final;
            vsh_q   <= vsh_d;
            lsh_q   <= lsh_d;
            if (accept) begin
                addr_q <= 14'(col_q);
                data_q <= s_data;
            end
        end
    end

endmodule
